// File: rtl/jtframe_colmix_pkg.sv
// Shared types and constants for the priority colour mixer.
package jtframe_colmix_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_LO = 2'd1,
        RD_HI = 2'd2,
        CALC  = 2'd3
    } fetch_st_e;

    localparam logic [7:0] PRIO_RST_DEF = 8'hE4;
    localparam int         LW           = 2;

    // Palette address: {hi/lo byte select, layer, pixel}
    function automatic int pal_aw(input int pxlw);
        return LW + pxlw + 1;
    endfunction

endpackage

// File: rtl/jtframe_colmix_sel.sv
// Combinational resolver: front-most opaque enabled layer, else deepest enabled backdrop.
module jtframe_colmix_sel
    import jtframe_colmix_pkg::*;
#(
    parameter int LAYERS = 4,
    parameter int PXLW   = 6,
    parameter int BLNKW  = 3
) (
    input  logic [LAYERS*PXLW-1:0] layer_pxl,
    input  logic [LAYERS-1:0]      gfx_en,
    input  logic [7:0]             prio,
    output logic [LW-1:0]          layer,
    output logic [PXLW-1:0]        pixel,
    output logic                   valid
);

    logic [PXLW-1:0] pxl_s [4];
    logic [3:0]      en_s;

    for (genvar k = 0; k < 4; k++) begin : g_pad
        if (k < LAYERS) begin : g_on
            assign pxl_s[k] = layer_pxl[k*PXLW +: PXLW];
            assign en_s[k]  = gfx_en[k];
        end else begin : g_off
            assign pxl_s[k] = {PXLW{1'b0}};
            assign en_s[k]  = 1'b0;
        end
    end

    // Walk depth fields front to back; the backdrop keeps the last usable field
    always_comb begin
        logic [1:0] id_v;
        logic       use_v;
        logic       hit_v;
        logic       found_v;
        logic [1:0] win_v;
        logic [1:0] bd_v;
        logic       bd_ok_v;
        id_v    = 2'd0;
        use_v   = 1'b0;
        hit_v   = 1'b0;
        found_v = 1'b0;
        win_v   = 2'd0;
        bd_v    = 2'd0;
        bd_ok_v = 1'b0;
        for (int f = 0; f < 4; f++) begin
            id_v    = prio[2*f +: 2];
            use_v   = (32'(id_v) < LAYERS) && en_s[id_v];
            hit_v   = use_v && !found_v && (|pxl_s[id_v][BLNKW-1:0]);
            win_v   = hit_v ? id_v : win_v;
            found_v = found_v | hit_v;
            bd_v    = use_v ? id_v : bd_v;
            bd_ok_v = bd_ok_v | use_v;
        end
        layer = found_v ? win_v : bd_v;
        pixel = pxl_s[layer];
        valid = bd_ok_v;
    end

endmodule

// File: rtl/jtframe_dual_ram.sv
// Byte-wide dual-port RAM: port 0 read/write, port 1 read-only, registered reads.
module jtframe_dual_ram #(
    parameter int DW = 8,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic [DW-1:0] data0,
    input  logic [AW-1:0] addr0,
    input  logic          we0,
    output logic [DW-1:0] q0,
    input  logic [AW-1:0] addr1,
    output logic [DW-1:0] q1
);

    logic [DW-1:0] mem_r [2**AW];

    // Reads return the pre-write contents when both ports hit the same address
    always_ff @(posedge clk) begin
        if (we0) mem_r[addr0] <= data0;
        q0 <= mem_r[addr0];
        q1 <= mem_r[addr1];
    end

endmodule

// File: rtl/jtframe_colmix_prio.sv
// Priority colour mixer: layer select, two-byte palette fetch, fade and blanked RGB output.
module jtframe_colmix_prio
    import jtframe_colmix_pkg::*;
#(
    parameter int         LAYERS   = 4,
    parameter int         PXLW     = 6,
    parameter int         BLNKW    = 3,
    parameter int         CW       = 4,
    parameter logic [7:0] PRIO_RST = PRIO_RST_DEF,
    localparam int        AW       = pal_aw(PXLW)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pxl_cen,
    input  logic                   LHBL,
    input  logic                   LVBL,
    input  logic [LAYERS*PXLW-1:0] layer_pxl,
    input  logic [LAYERS-1:0]      gfx_en,
    input  logic                   pal_cs,
    input  logic                   reg_cs,
    input  logic                   cpu_wrn,
    input  logic [AW-1:0]          cpu_addr,
    input  logic [7:0]             cpu_dout,
    output logic [7:0]             pal_dout,
    output logic [CW-1:0]          red,
    output logic [CW-1:0]          green,
    output logic [CW-1:0]          blue
);

    logic [7:0]      prio_sh_r, prio_act_r;
    logic [3:0]      fade_sh_r, fade_act_r;
    logic            lvbl_r;
    logic            reg_we_s, lvbl_fall_s;

    fetch_st_e       state_r, state_nx_s;
    logic [AW-2:0]   sel_s, sel_r;
    logic [LW-1:0]   sel_layer_s;
    logic [PXLW-1:0] sel_pixel_s;
    logic            sel_valid_s, valid_r, blank_r;
    logic [AW-1:0]   vaddr_r, vaddr_nx_s;
    logic            lo_cap_s, calc_s;
    logic [7:0]      pal_q_s, lo_r;
    logic [15:0]     word_s;
    logic            word_unused_s;
    logic [3*CW-1:0] col_r;

    assign reg_we_s      = reg_cs & ~cpu_wrn;
    assign lvbl_fall_s   = lvbl_r & ~LVBL;
    assign sel_s         = {sel_layer_s, sel_pixel_s};
    assign word_s        = {pal_q_s, lo_r};
    assign word_unused_s = ^word_s[15:3*CW];

    function automatic logic [CW-1:0] fade_ch(input logic [CW-1:0] c, input logic [3:0] f);
        logic [4:0]    mul_v;
        logic [CW+4:0] prod_v;
        mul_v  = 5'd16 - {1'b0, f};
        prod_v = (CW+5)'(c) * (CW+5)'(mul_v);
        return prod_v[CW+3:4];
    endfunction

    jtframe_colmix_sel #(
        .LAYERS (LAYERS),
        .PXLW   (PXLW),
        .BLNKW  (BLNKW)
    ) u_sel (
        .layer_pxl (layer_pxl),
        .gfx_en    (gfx_en),
        .prio      (prio_act_r),
        .layer     (sel_layer_s),
        .pixel     (sel_pixel_s),
        .valid     (sel_valid_s)
    );

    jtframe_dual_ram #(
        .DW (8),
        .AW (AW)
    ) u_pal (
        .clk   (clk),
        .data0 (cpu_dout),
        .addr0 (cpu_addr),
        .we0   (pal_cs & ~cpu_wrn),
        .q0    (pal_dout),
        .addr1 (vaddr_r),
        .q1    (pal_q_s)
    );

    // Shadow registers; an LVBL fall copies the pre-write shadow into the active set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_sh_r  <= PRIO_RST;
            prio_act_r <= PRIO_RST;
            fade_sh_r  <= 4'd0;
            fade_act_r <= 4'd0;
            lvbl_r     <= 1'b0;
        end else begin
            lvbl_r <= LVBL;
            if (reg_we_s && !cpu_addr[0]) prio_sh_r <= cpu_dout;
            if (reg_we_s &&  cpu_addr[0]) fade_sh_r <= cpu_dout[3:0];
            if (lvbl_fall_s) begin
                prio_act_r <= prio_sh_r;
                fade_act_r <= fade_sh_r;
            end
        end
    end

    // Fetch state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_nx_s;
    end

    // Next state: a pixel enable always restarts the fetch
    always_comb begin
        state_nx_s = state_r;
        if (pxl_cen) begin
            state_nx_s = RD_LO;
        end else begin
            case (state_r)
                IDLE:    state_nx_s = IDLE;
                RD_LO:   state_nx_s = RD_HI;
                RD_HI:   state_nx_s = CALC;
                CALC:    state_nx_s = IDLE;
                default: state_nx_s = IDLE;
            endcase
        end
    end

    // Fetch controls: palette address sequencing and byte capture strobes
    always_comb begin
        vaddr_nx_s = vaddr_r;
        lo_cap_s   = 1'b0;
        calc_s     = 1'b0;
        if (pxl_cen) begin
            vaddr_nx_s = {1'b0, sel_s};
        end else begin
            case (state_r)
                RD_LO:   vaddr_nx_s = {1'b1, sel_r};
                RD_HI:   lo_cap_s   = 1'b1;
                CALC:    calc_s     = 1'b1;
                default: vaddr_nx_s = vaddr_r;
            endcase
        end
    end

    // Pixel datapath; RGB on each pixel enable reflects the previous pixel's colour
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_r   <= '0;
            valid_r <= 1'b0;
            blank_r <= 1'b1;
            vaddr_r <= '0;
            lo_r    <= 8'd0;
            col_r   <= '0;
            red     <= '0;
            green   <= '0;
            blue    <= '0;
        end else begin
            vaddr_r <= vaddr_nx_s;
            if (pxl_cen) begin
                sel_r   <= sel_s;
                valid_r <= sel_valid_s;
                blank_r <= ~LVBL | ~LHBL;
                red     <= blank_r ? '0 : col_r[3*CW-1:2*CW];
                green   <= blank_r ? '0 : col_r[2*CW-1:CW];
                blue    <= blank_r ? '0 : col_r[CW-1:0];
            end
            if (lo_cap_s) lo_r <= pal_q_s;
            if (calc_s) begin
                col_r <= valid_r ? {fade_ch(word_s[CW-1:0],      fade_act_r),
                                    fade_ch(word_s[2*CW-1:CW],   fade_act_r),
                                    fade_ch(word_s[3*CW-1:2*CW], fade_act_r)} : '0;
            end
        end
    end

endmodule

// File: tb/tb_jtframe_colmix_prio.sv
// Scoreboard bench: each issued pixel queues its expected RGB, checked one pixel period later.
module tb_jtframe_colmix_prio;

    logic        clk = 1'b0;
    logic        rst_n, pxl_cen, LHBL, LVBL;
    logic [23:0] layer_pxl;
    logic [3:0]  gfx_en;
    logic        pal_cs, reg_cs, cpu_wrn;
    logic [8:0]  cpu_addr;
    logic [7:0]  cpu_dout;
    logic [7:0]  pal_dout;
    logic [3:0]  red, green, blue;

    typedef struct { logic chk; logic [11:0] rgb; int id; } exp_t;
    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   pix_n  = 0;

    always #5 clk = ~clk;

    jtframe_colmix_prio dut (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
        .layer_pxl(layer_pxl), .gfx_en(gfx_en), .pal_cs(pal_cs), .reg_cs(reg_cs),
        .cpu_wrn(cpu_wrn), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .pal_dout(pal_dout), .red(red), .green(green), .blue(blue)
    );

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // Monitor: at each pixel enable the output belongs to the pixel before the newest
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (pxl_cen && rst_n) begin
                #1;
                if (exp_q.size() >= 2) begin
                    e = exp_q.pop_front();
                    if (e.chk) check($sformatf("pix%0d", e.id), {red, green, blue}, e.rgb);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic pixel(input logic [5:0] l0, l1, l2, l3, input logic [3:0] en,
                         input logic hb, input logic chk, input logic [11:0] rgb);
        @(negedge clk);
        layer_pxl = {l3, l2, l1, l0};
        gfx_en    = en;
        LHBL      = hb;
        pxl_cen   = 1'b1;
        exp_q.push_back('{chk, rgb, pix_n});
        pix_n++;
        @(negedge clk);
        pxl_cen = 1'b0;
        LHBL    = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic cpu_wr(input logic pal, input logic [8:0] a, input logic [7:0] d);
        @(negedge clk);
        pal_cs   = pal;
        reg_cs   = ~pal;
        cpu_addr = a;
        cpu_dout = d;
        cpu_wrn  = 1'b0;
        @(negedge clk);
        cpu_wrn = 1'b1;
        pal_cs  = 1'b0;
        reg_cs  = 1'b0;
    endtask

    task automatic pal_entry(input logic [7:0] sel, input logic [7:0] lo, input logic [7:0] hi);
        cpu_wr(1'b1, {1'b0, sel}, lo);
        cpu_wr(1'b1, {1'b1, sel}, hi);
    endtask

    task automatic vblank();
        @(negedge clk);
        LVBL = 1'b0;
        @(negedge clk);
        LVBL = 1'b1;
    endtask

    // Priority write landing on the same clk as the LVBL fall
    task automatic wr_at_vblank(input logic [7:0] d);
        @(negedge clk);
        reg_cs   = 1'b1;
        cpu_addr = 9'h000;
        cpu_dout = d;
        cpu_wrn  = 1'b0;
        LVBL     = 1'b0;
        @(negedge clk);
        reg_cs  = 1'b0;
        cpu_wrn = 1'b1;
        LVBL    = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; pxl_cen = 1'b0; LHBL = 1'b1; LVBL = 1'b1;
        layer_pxl = 24'd0; gfx_en = 4'b1111;
        pal_cs = 1'b0; reg_cs = 1'b0; cpu_wrn = 1'b1; cpu_addr = 9'd0; cpu_dout = 8'd0;
        repeat (3) @(negedge clk);
        check("reset_rgb", {red, green, blue}, 12'h000);
        rst_n = 1'b1;

        pal_entry(8'h00, 8'h21, 8'h03);
        pal_entry(8'h05, 8'h21, 8'h03);
        pal_entry(8'h49, 8'h54, 8'h06);
        pal_entry(8'hC8, 8'h87, 8'h09);
        pal_entry(8'h90, 8'hBA, 8'h0C);
        pal_entry(8'h01, 8'hFF, 8'h0F);

        @(negedge clk);
        pal_cs = 1'b1; cpu_wrn = 1'b1; cpu_addr = 9'h049;
        @(posedge clk); #1;
        check("pal_readback", {4'd0, pal_dout}, 12'h054);
        @(negedge clk);
        pal_cs = 1'b0;

        pixel(6'h00, 6'h00, 6'h00, 6'h00, 4'b0001, 1'b1, 1'b1, 12'h123);
        pixel(6'h05, 6'h09, 6'h10, 6'h08, 4'b1111, 1'b1, 1'b1, 12'h123);
        cpu_wr(1'b0, 9'h000, 8'h1B);
        pixel(6'h05, 6'h09, 6'h10, 6'h08, 4'b1111, 1'b1, 1'b1, 12'h123);
        vblank();
        pixel(6'h05, 6'h09, 6'h10, 6'h08, 4'b1111, 1'b1, 1'b1, 12'h456);
        pixel(6'h05, 6'h09, 6'h10, 6'h08, 4'b0000, 1'b1, 1'b1, 12'h000);
        pixel(6'h05, 6'h09, 6'h10, 6'h08, 4'b0100, 1'b1, 1'b1, 12'hABC);
        pixel(6'h05, 6'h09, 6'h10, 6'h08, 4'b1111, 1'b1, 1'b1, 12'h456);
        pixel(6'h05, 6'h09, 6'h10, 6'h08, 4'b1111, 1'b0, 1'b1, 12'h000);
        pixel(6'h05, 6'h09, 6'h10, 6'h08, 4'b1111, 1'b1, 1'b1, 12'h456);
        wr_at_vblank(8'hE4);
        pixel(6'h05, 6'h09, 6'h10, 6'h08, 4'b1111, 1'b1, 1'b1, 12'h456);
        vblank();
        pixel(6'h05, 6'h09, 6'h10, 6'h08, 4'b1111, 1'b1, 1'b1, 12'h123);

        cpu_wr(1'b0, 9'h001, 8'h08);
        vblank();
        pixel(6'h01, 6'h00, 6'h00, 6'h00, 4'b0001, 1'b1, 1'b1, 12'h777);
        cpu_wr(1'b0, 9'h001, 8'h0F);
        vblank();
        pixel(6'h01, 6'h00, 6'h00, 6'h00, 4'b0001, 1'b1, 1'b1, 12'h000);
        cpu_wr(1'b0, 9'h001, 8'h00);
        vblank();
        pixel(6'h01, 6'h00, 6'h00, 6'h00, 4'b0001, 1'b1, 1'b1, 12'hFFF);

        cpu_wr(1'b0, 9'h000, 8'h1B);
        vblank();
        pixel(6'h05, 6'h09, 6'h10, 6'h08, 4'b1111, 1'b1, 1'b1, 12'h456);

        // Start a fetch, then reset while it sits in RD_HI
        @(negedge clk);
        pxl_cen = 1'b1;
        exp_q.push_back('{1'b0, 12'h000, pix_n});
        pix_n++;
        @(negedge clk);
        pxl_cen = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_fetch", {red, green, blue}, 12'h000);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        pixel(6'h05, 6'h09, 6'h10, 6'h08, 4'b1111, 1'b1, 1'b1, 12'h123);
        pixel(6'h00, 6'h00, 6'h00, 6'h00, 4'b0000, 1'b1, 1'b0, 12'h000);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
